mux_5: RTL and testbench
========================

# mux_5

Five-input, one-bit selector: drives output `y` from one bit of the 5-bit input bus `a`, chosen by the 3-bit select `s`. Select codes 5–7 are out of range. For those codes the block forces `y` to 0, raises a flag and counts the event. It sits in datapath glue logic wherever a narrow one-of-five choice is needed. The counter lets a controller detect bad select codes.

## Interface
Parameters:
- `ERR_CNT_W`, default 8: width of the saturating out-of-range counter.

Ports:
- `clk`  in  1: single clock; every register uses the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `a`  in  5: data inputs; bit `a[k]` is input k.
- `s`  in  3: select code; 0–4 are valid, 5–7 are out of range.
- `y`  out  1: selected bit (timing set by the configuration macro).
- `sel_err`  out  1: combinational; high when `s` ≥ 5.
- `err_cnt`  out  `ERR_CNT_W`: saturating count of clock edges that saw `s` ≥ 5.

## Operation
- Selection function: `f(a,s) = a[s]` for `s` in 0..4; `f(a,s) = 1'b0` for `s` in 5..7.
- `y` never goes X or Z when `a` and `s` are known; it matches `f` under 4-state equality.
- `sel_err = (s >= 3'd5)`, purely combinational in every configuration.
- `err_cnt` update at each rising `clk` with `rst_n` high:
  - `sel_err` = 1 and `err_cnt` below 2^`ERR_CNT_W`−1: `err_cnt` increments by 1.
  - `sel_err` = 1 and `err_cnt` at the maximum: `err_cnt` holds; it never wraps.
  - `sel_err` = 0: `err_cnt` holds.
- `err_cnt` width arithmetic: unsigned, `ERR_CNT_W` bits; the saturation compare is against all-ones.
- There is no software clear; only `rst_n` clears `err_cnt`.

## Timing
- `rst_n` low:
  - Takes effect immediately, with no clock needed.
  - `err_cnt` = 0.
  - Registered `y` (macro defined) = 0.
  - `sel_err` keeps following `s`.
- Reset release: registers update from the first rising edge at which `rst_n` is sampled high.
- Reset asserted mid-operation: `err_cnt` and registered `y` clear at once; an increment pending on the next edge is lost.
- Combinational `y` (macro undefined):
  - Zero-cycle latency; any change on `a` or `s` shows on `y` after propagation delay only.
  - Reset has no effect on `y`.
- Registered `y` (macro defined): one-cycle latency; `y` becomes `f(a,s)` as sampled at the rising edge.
- `err_cnt` is always registered; it reflects `sel_err` sampled at the preceding edge.

## Configuration
- Macro `MUX5_REGISTERED_OUT_EN`.
- Defined:
  - `y` comes from a flip-flop loaded with `f(a,s)` on every rising edge.
  - The flip-flop resets asynchronously to 0.
- Undefined:
  - `y` is combinational `f(a,s)` with no flop.
  - `clk` and `rst_n` serve only `err_cnt`.
- `sel_err` and `err_cnt` behave the same in both builds.

## Test plan
- Exhaustive sweep, macro undefined:
  - Stimulus: all 256 combinations of `a` (0..31) and `s` (0..7), 1 ns apart.
  - Response: `y === f(a,s)` after each step, e.g. `a=5'b10100, s=2` gives `y=1`, and `s=6` gives `y=0`.
  - Zero mismatches.
- Out-of-range flag and count:
  - Stimulus: reset, then hold `s=7`, `a=5'b11111` for 3 edges.
  - Response: `sel_err=1` and `y=0` throughout; `err_cnt` reads 1, 2, 3.
  - Then `s=0`: `sel_err=0`, `y=1`, `err_cnt` holds at 3.
- Saturation:
  - Stimulus: `ERR_CNT_W=2`, hold `s=5` for 6 edges.
  - Response: `err_cnt` reads 1, 2, 3, 3, 3, 3; it never returns to 0.
- Asynchronous reset mid-operation:
  - Stimulus: `err_cnt=3`, then drop `rst_n` between clock edges.
  - Response: `err_cnt=0` immediately; it stays 0 while `rst_n` is low, even with `s=6` and `clk` toggling.
- Registered build (`MUX5_REGISTERED_OUT_EN` defined):
  - Stimulus: change `a=5'b00010, s=1` just after an edge.
  - Response: `y` stays at its old value until the next rising edge, then `y=1`.
  - During reset `y=0`.

Source files
------------

// File: rtl/mux_5.sv
// One-of-five bit selector with an out-of-range select flag and a saturating error counter.
// Define MUX5_REGISTERED_OUT_EN to register y; by default y is combinational.
`timescale 1ns/1ps

module mux_5 #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           a,
    input  logic [2:0]           s,
    output logic                 y,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Select codes 5..7 fall to the default arm and produce 0.
    function automatic logic select_bit(input logic [4:0] d, input logic [2:0] code);
        logic r;
        r = 1'b0;
        case (code)
            3'd0:    r = d[0];
            3'd1:    r = d[1];
            3'd2:    r = d[2];
            3'd3:    r = d[3];
            3'd4:    r = d[4];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        logic [ERR_CNT_W-1:0] r;
        r = cnt;
        if (!(&cnt)) begin
            r = cnt + ERR_CNT_W'(1);
        end
        return r;
    endfunction

    logic f_p0;

    assign f_p0    = select_bit(a, s);
    assign sel_err = (s >= 3'd5);

    // Stage p0 -> p1: error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (sel_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

`ifdef MUX5_REGISTERED_OUT_EN
    logic y_p1;

    // Stage p0 -> p1: registered selector output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1 <= 1'b0;
        end else begin
            y_p1 <= f_p0;
        end
    end

    assign y = y_p1;
`else
    assign y = f_p0;
`endif

endmodule

// File: tb/tb_mux_5.sv
// Scoreboard bench for mux_5: stimulus pushes expected responses, a negedge monitor pops and checks.
// Two DUTs share inputs: default counter width and a 2-bit counter to reach saturation quickly.
`timescale 1ns/1ps

module tb_mux_5;

    logic       clk;
    logic       rst_n;
    logic [4:0] a;
    logic [2:0] s;
    logic       y, y2;
    logic       sel_err, sel_err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       y;
        logic       se;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    int  m_c8 = 0;
    int  m_c2 = 0;
    logic m_yreg = 1'b0;

    mux_5 #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .s(s),
        .y(y), .sel_err(sel_err), .err_cnt(err_cnt)
    );

    mux_5 #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .s(s),
        .y(y2), .sel_err(sel_err2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_f(input int av, input int sv);
        if (sv < 5) return logic'((av >> sv) & 1);
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: apply inputs, queue expectation, then advance the model across the next edge.
    task automatic cycle(input int av, input int sv, input logic rv);
        exp_t e;
        a     = 5'(av);
        s     = 3'(sv);
        rst_n = rv;
        if (!rv) begin
            m_c8   = 0;
            m_c2   = 0;
            m_yreg = 1'b0;
        end
`ifdef MUX5_REGISTERED_OUT_EN
        e.y  = m_yreg;
`else
        e.y  = model_f(av, sv);
`endif
        e.se = (sv >= 5);
        e.c8 = 8'(m_c8);
        e.c2 = 2'(m_c2);
        exp_q.push_back(e);
        @(posedge clk);
        if (rv) begin
            if (sv >= 5) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3)   m_c2++;
            end
            m_yreg = model_f(av, sv);
        end
        #1;
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("y",        {31'd0, y},        {31'd0, e.y});
            check("y_w2",     {31'd0, y2},       {31'd0, e.y});
            check("sel_err",  {31'd0, sel_err},  {31'd0, e.se});
            check("err_cnt",  {24'd0, err_cnt},  {24'd0, e.c8});
            check("err_cnt2", {30'd0, err_cnt2}, {30'd0, e.c2});
        end
    end

    initial begin
        int drained;
        a     = '0;
        s     = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        for (int i = 0; i < 3; i++) cycle(0, i, 1'b0);

        // out-of-range flag and count
        for (int i = 0; i < 3; i++) cycle(5'h1f, 7, 1'b1);
        for (int i = 0; i < 2; i++) cycle(5'h1f, 0, 1'b1);

        // saturation of the 2-bit counter
        for (int i = 0; i < 6; i++) cycle(int'($urandom_range(0, 31)), 5, 1'b1);

        // registered-output latency pattern
        cycle(5'b00000, 0, 1'b1);
        cycle(5'b00010, 1, 1'b1);
        cycle(5'b00010, 1, 1'b1);

        // reset mid-operation, held low while selecting out of range
        for (int i = 0; i < 4; i++) cycle(5'h1f, 6, 1'b0);

        // exhaustive sweep
        for (int sv = 0; sv < 8; sv++)
            for (int av = 0; av < 32; av++)
                cycle(av, sv, 1'b1);

        // random traffic with occasional resets
        for (int i = 0; i < 700; i++)
            cycle(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) != 0));

        drained = 0;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) begin
                drained = 1;
                break;
            end
            @(posedge clk);
        end
        check("scoreboard_drain", 32'(drained), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
